// File: rtl/floor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : floor_pkg                                                  |
// | Description : Shared types and constants for the floor datapath:         |
// |               game-state encoding, screen bounds, the floor x spacing    |
// |               and a helper that turns a difficulty level into the mask   |
// |               applied to the tick phase when deciding whether to step.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package floor_pkg;

  // Game state encoding, also driven directly onto the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Horizontal spacing of legal floor positions.
  localparam int FLOOR_X_STEP = 40;

  // Visible playfield.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Pixel coordinate on either axis.
  typedef logic [9:0] coord_t;

  // Level n steps once every 2**n ticks, so the low n bits of the tick
  // phase must be zero on a stepping tick.
  function automatic logic [2:0] step_mask(input logic [1:0] lvl);
    logic [2:0] m;
    case (lvl)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/floor_scroll_sched_lfsr10.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr10                                                     |
// | Description : Free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1.        |
// |               Shifts towards the MSB every clock; the feedback bit is    |
// |               bit9 ^ bit6 and enters at bit0. Maximal length, so a       |
// |               nonzero seed never reaches the all-zero lock-up state.     |
// | Ports       : clk     - system clock                                     |
// |               rst     - synchronous active-high reset, loads SEED        |
// |               value_o - current LFSR contents                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h001
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] value_o
);

  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/floor_scroll_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : floor_scroll_sched                                         |
// | Description : Sequences the floor-position datapath. Turns frame ticks   |
// |               into one-cycle scroll steps at a rate set by a difficulty  |
// |               level that rises with play time, and requests new floors   |
// |               over a valid/ready handshake with a pseudo-random x.       |
// | Ports       : clk, rst     - clock, synchronous active-high reset        |
// |               tick         - one-cycle frame tick                        |
// |               start        - begin play (IDLE->RUN, OVER->IDLE)          |
// |               pause        - hold play while high                        |
// |               game_over    - end play (highest priority)                 |
// |               hit_ceiling  - freezes tick counting and stepping          |
// |               spawn_ready  - floor bank accepts the pending spawn        |
// |               step         - one-cycle scroll pulse                      |
// |               level        - difficulty 0..3                             |
// |               spawn_valid  - spawn request pending                       |
// |               spawn_x      - x of the requested floor, 0..600 step 40    |
// |               spawn_drop   - sticky, a spawn was lost while pending      |
// |               state        - IDLE=0 RUN=1 PAUSE=2 OVER=3                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module floor_scroll_sched
  import floor_pkg::*;
#(
  parameter int         LEVEL_TICKS = 80,
  parameter int         SPAWN_PITCH = 60,
  parameter logic [9:0] LFSR_SEED   = 10'h001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       hit_ceiling,
  input  logic       spawn_ready,
  output logic       step,
  output logic [1:0] level,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic       spawn_drop,
  output logic [1:0] state
);

  localparam int TIMER_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam int SCROLL_W = (SPAWN_PITCH > 1) ? $clog2(SPAWN_PITCH) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(LEVEL_TICKS - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SPAWN_PITCH - 1);
  localparam coord_t X_STEP = coord_t'(FLOOR_X_STEP);

  state_e              state_q,  state_d;
  logic                step_q,   step_d;
  logic [1:0]          level_q,  level_d;
  logic [2:0]          phase_q,  phase_d;
  logic [TIMER_W-1:0]  timer_q,  timer_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic                valid_q,  valid_d;
  coord_t              x_q,      x_d;
  logic                drop_q,   drop_d;

  logic [9:0] w_lfsr;
  logic [5:0] w_lfsr_hi_unused;
  logic       w_counted;
  logic       w_scroll_en;
  logic       w_wrap;
  logic       w_accept;

  lfsr10 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .value_o (w_lfsr)
  );

  // Only the low nibble picks the floor slot.
  assign w_lfsr_hi_unused = w_lfsr[9:4];

  always_comb begin
    state_d  = state_q;
    step_d   = 1'b0;
    level_d  = level_q;
    phase_d  = phase_q;
    timer_d  = timer_q;
    scroll_d = scroll_q;
    valid_d  = valid_q;
    x_d      = x_q;
    drop_d   = drop_q;

    // A tick only counts while running and not pinned at the ceiling.
    w_counted   = (state_q == ST_RUN) && tick && !hit_ceiling;
    // A step leaving RUN on a pause still scrolls the floors, so it must
    // also advance the spawn pitch; after game over it is ignored.
    w_scroll_en = step_q && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
    w_wrap      = w_scroll_en && (scroll_q == SCROLL_LAST);
    w_accept    = valid_q && spawn_ready;

    if (w_counted) begin
      // Step decision uses the phase and level before this tick updates them.
      step_d  = ((phase_q & step_mask(level_q)) == 3'd0);
      phase_d = phase_q + 3'd1;
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        if (level_q != 2'd3) begin
          level_d = level_q + 2'd1;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (w_scroll_en) begin
      scroll_d = w_wrap ? '0 : scroll_q + 1'b1;
    end

    // A wrap landing on the accepting cycle refills the slot without a drop.
    if (w_wrap) begin
      if (!valid_q || w_accept) begin
        valid_d = 1'b1;
        x_d     = coord_t'(w_lfsr[3:0]) * X_STEP;
      end else begin
        drop_d = 1'b1;
      end
    end else if (w_accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_RUN;
      ST_RUN: begin
        if (game_over)          state_d = ST_OVER;
        else if (pause)         state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (game_over)          state_d = ST_OVER;
        else if (!pause)        state_d = ST_RUN;
      end
      ST_OVER:  if (start)      state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase

    if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
      valid_d = 1'b0;
    end

    // A fresh game starts from the easiest level with no history.
    if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      level_d  = 2'd0;
      phase_d  = 3'd0;
      timer_d  = '0;
      scroll_d = '0;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= 1'b0;
      level_q  <= 2'd0;
      phase_q  <= 3'd0;
      timer_q  <= '0;
      scroll_q <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      scroll_q <= scroll_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      drop_q   <= drop_d;
    end
  end

  assign step        = step_q;
  assign level       = level_q;
  assign spawn_valid = valid_q;
  assign spawn_x     = x_q;
  assign spawn_drop  = drop_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_scroll_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_floor_scroll_sched                                      |
// | Description : Randomized self-checking bench for floor_scroll_sched.     |
// |               A behavioural model tracks the game rules with integer     |
// |               arithmetic and is compared against every output each cycle.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_floor_scroll_sched;

  localparam int         LT   = 4;
  localparam int         SP   = 3;
  localparam logic [9:0] SEED = 10'h001;
  localparam int         NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst, tick, start, pause, game_over, hit_ceiling, spawn_ready;
  logic       step, spawn_valid, spawn_drop;
  logic [1:0] level, state;
  logic [9:0] spawn_x;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state (0=IDLE 1=RUN 2=PAUSE 3=OVER).
  int m_st, m_level, m_timer, m_phase, m_scroll;
  int m_valid, m_x, m_drop, m_step, m_lfsr;

  floor_scroll_sched #(
    .LEVEL_TICKS (LT),
    .SPAWN_PITCH (SP),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .pause       (pause),
    .game_over   (game_over),
    .hit_ceiling (hit_ceiling),
    .spawn_ready (spawn_ready),
    .step        (step),
    .level       (level),
    .spawn_valid (spawn_valid),
    .spawn_x     (spawn_x),
    .spawn_drop  (spawn_drop),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_level = 0; m_timer = 0; m_phase = 0; m_scroll = 0;
    m_valid = 0; m_x = 0; m_drop = 0; m_step = 0; m_lfsr = int'(SEED);
  endtask

  // One clock of game rules, applied to the inputs currently driven.
  task automatic model_clock();
    int  n_st, n_level, n_timer, n_phase, n_scroll, n_valid, n_x, n_drop, n_step;
    bit  counted, scrolls, wrap, taken;
    if (rst) begin
      model_reset();
      return;
    end
    n_st = m_st; n_level = m_level; n_timer = m_timer; n_phase = m_phase;
    n_scroll = m_scroll; n_valid = m_valid; n_x = m_x; n_drop = m_drop;

    counted = (m_st == 1) && tick && !hit_ceiling;
    // Level n steps every 2**n counted ticks.
    n_step  = (counted && (m_phase % (1 << m_level) == 0)) ? 1 : 0;
    if (counted) begin
      n_phase = (m_phase + 1) % 8;
      if (m_timer == LT - 1) begin
        n_timer = 0;
        n_level = (m_level < 3) ? m_level + 1 : 3;
      end else begin
        n_timer = m_timer + 1;
      end
    end

    scrolls = m_step && (m_st == 1 || m_st == 2);
    wrap    = scrolls && (m_scroll == SP - 1);
    taken   = m_valid && spawn_ready;
    if (scrolls) n_scroll = (m_scroll + 1) % SP;
    if (wrap) begin
      if (!m_valid || taken) begin
        n_valid = 1;
        n_x     = (m_lfsr % 16) * 40;
      end else begin
        n_drop = 1;
      end
    end else if (taken) begin
      n_valid = 0;
    end

    case (m_st)
      0: if (start) n_st = 1;
      1: if (game_over) n_st = 3; else if (pause) n_st = 2;
      2: if (game_over) n_st = 3; else if (!pause) n_st = 1;
      default: if (start) n_st = 0;
    endcase
    if (n_st == 3 && m_st != 3) n_valid = 0;
    if (m_st == 0 && n_st == 1) begin
      n_level = 0; n_timer = 0; n_phase = 0; n_scroll = 0; n_drop = 0;
    end

    m_st = n_st; m_level = n_level; m_timer = n_timer; m_phase = n_phase;
    m_scroll = n_scroll; m_valid = n_valid; m_x = n_x; m_drop = n_drop;
    m_step = n_step;
    // x^10 + x^7 + 1: new bit is bit9 xor bit6, shifted in at the bottom.
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 1023;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
    game_over = 1'b0; hit_ceiling = 1'b0; spawn_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_eq("state",       16'(state),       16'(m_st));
      check_eq("step",        16'(step),        16'(m_step));
      check_eq("level",       16'(level),       16'(m_level));
      check_eq("spawn_valid", 16'(spawn_valid), 16'(m_valid));
      check_eq("spawn_x",     16'(spawn_x),     16'(m_x));
      check_eq("spawn_drop",  16'(spawn_drop),  16'(m_drop));

      // First stretch keeps play alive to reach high levels and drops;
      // later stretch mixes in game over and occasional resets.
      rst         = (cyc == 0) || ((cyc > 1500) && ($urandom_range(0, 299) == 0));
      tick        = ($urandom_range(0, 1) == 0);
      start       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 24) == 0) hit_ceiling = ~hit_ceiling;
      game_over   = (cyc > 1000) && ($urandom_range(0, 119) == 0);
      spawn_ready = (cyc % 700 < 350) ? ($urandom_range(0, 5) == 0)
                                      : ($urandom_range(0, 1) == 0);
      model_clock();
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/floor_scroll_sched.md
# floor_scroll_sched

Scheduler that sequences the floor-position datapath of the game.
- Converts a per-frame tick into single-cycle `step` pulses that scroll all floors down 1 px, at a rate set by a difficulty level that rises over play time.
- Requests new-floor spawns over a valid/ready handshake, carrying a pseudo-random x position.
- Gates everything on game state: idle, run, pause and game over.
- Sits between the top-level game FSM/frame timer and the floor register bank.

## Interface
- `LEVEL_TICKS`, default 80: ticks spent in RUN before the level advances.
- `SPAWN_PITCH`, default 60: steps between spawn requests.
- `LFSR_SEED`, default 10'h001: LFSR reset value; must be nonzero.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `tick` input 1: one-cycle frame tick pulse.
- `start` input 1: level-sensitive request to begin play.
- `pause` input 1: level; holds play while high.
- `game_over` input 1: level; ends play.
- `hit_ceiling` input 1: level; player at ceiling, suppresses scrolling.
- `spawn_ready` input 1: floor bank accepts the spawn.
- `step` output 1: one-cycle scroll pulse.
- `level` output 2: current difficulty, 0–3.
- `spawn_valid` output 1: spawn request pending.
- `spawn_x` output 10: x position for the new floor, 0–600 in steps of 40.
- `spawn_drop` output 1: sticky flag, a spawn was lost.
- `state` output 2: IDLE=0, RUN=1, PAUSE=2, OVER=3.

## Operation
**State machine** (registered; `game_over` has highest priority):
- IDLE → RUN on `start`.
- RUN → OVER on `game_over`; otherwise RUN → PAUSE on `pause`.
- PAUSE → RUN when `pause` is low; PAUSE → OVER on `game_over`.
- OVER → IDLE on `start`. Re-entering RUN from IDLE clears `level`, the tick counters and `spawn_drop`.

**Counters and level** (RUN only; all counters hold in other states):
- On each `tick` in RUN with `hit_ceiling` low, increment the 3-bit `phase` and the level timer.
- When the timer reaches `LEVEL_TICKS-1`, it wraps to 0 and `level` increments, saturating at 3.
- `hit_ceiling` high freezes `phase`, the level timer and `step`.

**Step generation:**
- Step period in ticks is 1, 2, 4 or 8 for level 0, 1, 2 or 3.
- `step` fires on a counted tick when `phase` masked to the low `level` bits equals 0, using the pre-increment value.

**Spawn:**
- The scroll counter increments per `step` and wraps at `SPAWN_PITCH-1`.
- On wrap: if `spawn_valid` is low, set it and capture `spawn_x = lfsr[3:0]*40` (10-bit, max 600). If `spawn_valid` is already high, keep the pending request unchanged and set `spawn_drop`.
- `spawn_valid` and `spawn_x` hold stable until the cycle where `spawn_valid & spawn_ready`; `spawn_valid` clears after that cycle.
- Pending spawns survive PAUSE. Entering OVER clears `spawn_valid`.

**LFSR:** 10-bit Fibonacci, polynomial x^10+x^7+1, advances every clk including outside RUN, never zero.

## Timing
- All outputs are registered.
- Reset values: `step`=0, `level`=0, `spawn_valid`=0, `spawn_x`=0, `spawn_drop`=0, `state`=IDLE. LFSR resets to `LFSR_SEED`; all counters reset to 0.
- `step` is high the cycle after the qualifying `tick`.
- `spawn_valid` rises the cycle after the wrapping `step` (two cycles after its `tick`).
- State changes take effect the cycle after the input; a `tick` in that same cycle is evaluated against the old state.
- A `tick` coincident with `pause` or `game_over` assertion is still counted, since the state is still RUN.
- `rst` mid-handshake drops the request immediately; `spawn_ready` is ignored when `spawn_valid` is low.
- Same-cycle handshake completion and new wrap: the new request is captured, `spawn_valid` stays 1, and there is no drop.

## Structure
- Shared package `floor_pkg` holds:
  - State encoding enum.
  - `FLOOR_X_STEP`=40.
  - Screen bounds `SCREEN_W`=640 and `SCREEN_H`=480.
  - 10-bit coordinate typedef.
- One sub-module `lfsr10`: clk, rst, seed parameter, 10-bit output.
- FSM, counters and the spawn register remain in this block.

## Test plan
- **Level 0 scroll:** reset, `start`, 5 ticks → 5 `step` pulses, each one cycle after its tick; `state`=1.
- **Level progression:** `LEVEL_TICKS`=4, run 12 ticks → `level` 0→1→2→3; at level 2, exactly 1 `step` per 4 ticks; `level` saturates at 3 after 20 more ticks.
- **Ceiling and pause freeze:** `hit_ceiling` high for 10 ticks → no `step`, level timer frozen. `pause` for 10 ticks → `state`=2, no `step`. On release, stepping resumes at the same phase.
- **Spawn handshake:** `SPAWN_PITCH`=3, `spawn_ready`=0 → `spawn_valid` high after the 3rd step with `spawn_x` a multiple of 40 ≤600, held stable. 3 more steps → `spawn_drop`=1. `spawn_ready` pulse → `spawn_valid` low next cycle.
- **Game over priority:** `game_over` and `pause` asserted together in RUN → `state`=3, `spawn_valid` cleared. `start` → IDLE; `start` → RUN with `level`=0 and `spawn_drop`=0.
- **Reset mid-operation:** `rst` during RUN at level 2 with a spawn pending → next cycle all outputs at reset values.
